// File: rtl/wb_regfile_sb_pkg.sv
// wb_regfile_sb_pkg: shared register-file constants and the register address type
package wb_regfile_sb_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int PEND_W_DEF = 2;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    localparam reg_addr_t X0 = '0;
endpackage

// File: rtl/wb_regfile_sb_if.sv
// wb_regfile_sb_if: write-back, read-port and issue signals between pipeline and register file
// master = pipeline side (WB stage + decode), slave = register file / scoreboard
interface wb_regfile_sb_if #(parameter int size = 32);
    import wb_regfile_sb_pkg::*;
    reg_addr_t       RD_WB;
    logic            WE_WB;
    logic [size-1:0] Final_Result;
    reg_addr_t       RS1_addr_i;
    reg_addr_t       RS2_addr_i;
    logic [size-1:0] RS1_data_o;
    logic [size-1:0] RS2_data_o;
    logic            issue_valid_i;
    logic            issue_we_i;
    reg_addr_t       issue_rd_i;
    logic            flush_i;
    logic            RS1_busy_o;
    logic            RS2_busy_o;
    logic            stall_o;
    logic            wb_underflow_o;
    modport master (
        output RD_WB, WE_WB, Final_Result, RS1_addr_i, RS2_addr_i,
               issue_valid_i, issue_we_i, issue_rd_i, flush_i,
        input  RS1_data_o, RS2_data_o, RS1_busy_o, RS2_busy_o, stall_o, wb_underflow_o
    );
    modport slave (
        input  RD_WB, WE_WB, Final_Result, RS1_addr_i, RS2_addr_i,
               issue_valid_i, issue_we_i, issue_rd_i, flush_i,
        output RS1_data_o, RS2_data_o, RS1_busy_o, RS2_busy_o, stall_o, wb_underflow_o
    );
endinterface

// File: rtl/wb_regfile_sb_pending_counter.sv
// sb_pending_counter: saturating up/down count of in-flight writes to one register
// Ports: clk, reset (async active-low), i_inc, i_dec, i_clr; o_is_zero, o_is_one, o_is_max flags
module sb_pending_counter import wb_regfile_sb_pkg::*; #(
    parameter int W = PEND_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic i_inc,
    input  logic i_dec,
    input  logic i_clr,
    output logic o_is_zero,
    output logic o_is_one,
    output logic o_is_max
);
    logic [W-1:0] r_cnt;
    assign o_is_zero = r_cnt == '0;
    assign o_is_one  = r_cnt == W'(1);
    assign o_is_max  = &r_cnt;
    // simultaneous inc and dec cancel; ends of the range never wrap
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_inc && !i_dec && !o_is_max)
            r_cnt <= r_cnt + W'(1);
        else if (i_dec && !i_inc && !o_is_zero)
            r_cnt <= r_cnt - W'(1);
    end
endmodule

// File: rtl/wb_regfile_sb.sv
// wb_regfile_sb: 32-entry register file with WB bypass and pending-write scoreboard
// Ports: clk, reset (async active-low), bus (slave side of wb_regfile_sb_if:
// write-back, two combinational read ports, issue/flush, busy/stall/underflow status)
module wb_regfile_sb import wb_regfile_sb_pkg::*; #(
    parameter int size   = 32,
    parameter int depth  = NUM_REGS,
    parameter int PEND_W = PEND_W_DEF
) (
    input logic              clk,
    input logic              reset,
    wb_regfile_sb_if.slave   bus
);
    logic [size-1:0]  r_regs [depth];
    logic             r_underflow;
    logic [depth-1:0] w_zero, w_one, w_max;
    logic             w_wb_ok, w_issue_wr, w_rs1_busy, w_rs2_busy, w_stall;
    assign w_wb_ok    = bus.WE_WB && bus.RD_WB != X0;
    assign w_issue_wr = bus.issue_valid_i && bus.issue_we_i && bus.issue_rd_i != X0;
    // a single outstanding write that is retiring right now is covered by the bypass
    assign w_rs1_busy = bus.RS1_addr_i != X0 && !w_zero[bus.RS1_addr_i] &&
                        !(w_one[bus.RS1_addr_i] && w_wb_ok && bus.RD_WB == bus.RS1_addr_i);
    assign w_rs2_busy = bus.RS2_addr_i != X0 && !w_zero[bus.RS2_addr_i] &&
                        !(w_one[bus.RS2_addr_i] && w_wb_ok && bus.RD_WB == bus.RS2_addr_i);
    assign w_stall    = bus.issue_valid_i &&
                        (w_rs1_busy || w_rs2_busy || (w_issue_wr && w_max[bus.issue_rd_i]));
    assign bus.RS1_busy_o     = w_rs1_busy;
    assign bus.RS2_busy_o     = w_rs2_busy;
    assign bus.stall_o        = w_stall;
    assign bus.wb_underflow_o = r_underflow;
    assign bus.RS1_data_o = bus.RS1_addr_i == X0 ? '0 :
                            (w_wb_ok && bus.RD_WB == bus.RS1_addr_i) ? bus.Final_Result :
                            r_regs[bus.RS1_addr_i];
    assign bus.RS2_data_o = bus.RS2_addr_i == X0 ? '0 :
                            (w_wb_ok && bus.RD_WB == bus.RS2_addr_i) ? bus.Final_Result :
                            r_regs[bus.RS2_addr_i];
    // x0 has no counter: constant flags keep it never-busy and never-saturated
    for (genvar g = 0; g < depth; g++) begin : g_cnt
        if (g == 0) begin : g_x0
            assign w_zero[g] = 1'b1;
            assign w_one[g]  = 1'b0;
            assign w_max[g]  = 1'b0;
        end else begin : g_reg
            sb_pending_counter #(.W(PEND_W)) u_cnt (
                .clk       (clk),
                .reset     (reset),
                .i_inc     (w_issue_wr && !w_stall && !bus.flush_i && bus.issue_rd_i == reg_addr_t'(g)),
                .i_dec     (w_wb_ok && bus.RD_WB == reg_addr_t'(g)),
                .i_clr     (bus.flush_i),
                .o_is_zero (w_zero[g]),
                .o_is_one  (w_one[g]),
                .o_is_max  (w_max[g])
            );
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < depth; i++)
                r_regs[i] <= '0;
        end else if (w_wb_ok) begin
            r_regs[bus.RD_WB] <= bus.Final_Result;
        end
    end
    // a flush-cycle write-back is legitimate draining, so it never flags underflow
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_underflow <= 1'b0;
        else if (w_wb_ok && w_zero[bus.RD_WB] && !bus.flush_i)
            r_underflow <= 1'b1;
    end
endmodule
